operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch.sv | 153 +++++++++++++++
 tb/tb_operand_fetch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// operand_fetch: source-operand fetch with a RAW scoreboard and a one-entry output buffer.
// Build option FORWARD_EN: a writeback that lands in the same cycle can feed a waiting operand directly.
module operand_fetch #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_ra1,
  input  logic [3:0]       in_ra2,
  input  logic [3:0]       in_wa,
  input  logic             in_we,
  input  logic [WIDTH-1:0] in_pc,
  output logic [3:0]       rf_ra1,
  output logic [3:0]       rf_ra2,
  input  logic [WIDTH-1:0] rf_rd1,
  input  logic [WIDTH-1:0] rf_rd2,
  input  logic             wb_valid,
  input  logic [3:0]       wb_wa,
  input  logic [WIDTH-1:0] wb_wd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_op1,
  output logic [WIDTH-1:0] out_op2,
  output logic [3:0]       out_wa,
  output logic             out_we,
  output logic [15:0]      stall_cnt
);

  // state | meaning
  // EMPTY | nothing held for execute, out_valid=0
  // FULL  | one issued instruction held for execute, out_valid=1
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [3:0] PC_REG = 4'hF;

  state_t           state_q, state_d;
  logic [14:0]      pending_q, pending_d;
  logic [15:0]      pend_ext;
  logic             src1_pend, src2_pend;
  logic             fwd1, fwd2;
  logic             haz1, haz2;
  logic             hazard, issue;
  logic [WIDTH-1:0] pc_plus8;
  logic [WIDTH-1:0] op1_d, op2_d;

  assign rf_ra1 = in_ra1;
  assign rf_ra2 = in_ra2;

  // r15 reads as the PC, so its slot is tied off and never reports pending
  assign pend_ext  = {1'b0, pending_q};
  assign src1_pend = (in_ra1 != PC_REG) && pend_ext[in_ra1];
  assign src2_pend = (in_ra2 != PC_REG) && pend_ext[in_ra2];

`ifdef FORWARD_EN
  assign fwd1 = src1_pend && wb_valid && (wb_wa == in_ra1);
  assign fwd2 = src2_pend && wb_valid && (wb_wa == in_ra2);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  assign haz1   = src1_pend && !fwd1;
  assign haz2   = src2_pend && !fwd2;
  assign hazard = in_valid && (haz1 || haz2);

  assign in_ready  = reset && !hazard && ((state_q == EMPTY) || out_ready);
  assign issue     = in_valid && in_ready;
  assign out_valid = (state_q == FULL);

  assign pc_plus8 = in_pc + WIDTH'(8);

  always_comb begin
    op1_d = rf_rd1;
    op2_d = rf_rd2;
    if (in_ra1 == PC_REG) begin
      op1_d = pc_plus8;
    end else if (fwd1) begin
      op1_d = wb_wd;
    end
    if (in_ra2 == PC_REG) begin
      op2_d = pc_plus8;
    end else if (fwd2) begin
      op2_d = wb_wd;
    end
  end

  // the set is applied after the clear so a same-cycle issue write wins
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < 15; i++) begin
      if (wb_valid && (wb_wa == 4'(i))) begin
        pending_d[i] = 1'b0;
      end
      if (issue && in_we && (in_wa == 4'(i))) begin
        pending_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (issue) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (issue) begin
          state_d = FULL;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= EMPTY;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_op1 <= '0;
      out_op2 <= '0;
      out_wa  <= '0;
      out_we  <= 1'b0;
    end else if (issue) begin
      out_op1 <= op1_d;
      out_op2 <= op2_d;
      out_wa  <= in_wa;
      out_we  <= in_we;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (hazard && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: table-driven vectors with an output scoreboard queue, plus hand sequences
// for hold, set/clear priority, stall saturation and asynchronous reset.
module tb_operand_fetch;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [3:0]   in_ra1, in_ra2, in_wa;
  logic         in_we;
  logic [W-1:0] in_pc;
  logic [3:0]   rf_ra1, rf_ra2;
  logic [W-1:0] rf_rd1, rf_rd2;
  logic         wb_valid;
  logic [3:0]   wb_wa;
  logic [W-1:0] wb_wd;
  logic         out_valid, out_ready;
  logic [W-1:0] out_op1, out_op2;
  logic [3:0]   out_wa;
  logic         out_we;
  logic [15:0]  stall_cnt;

  operand_fetch #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ra1(in_ra1), .in_ra2(in_ra2), .in_wa(in_wa), .in_we(in_we), .in_pc(in_pc),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_valid(wb_valid), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_wa(out_wa), .out_we(out_we),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         iv;
    logic [3:0]   ra1, ra2, wa;
    logic         we;
    logic [W-1:0] pc, rd1, rd2;
    logic         wbv;
    logic [3:0]   wbwa;
    logic [W-1:0] wbwd;
    logic         ordy;
    logic         rdy;
    logic         haz;
    logic [W-1:0] e1, e2;
  } vec_t;

  typedef struct {
    logic [W-1:0] op1, op2;
    logic [3:0]   wa;
    logic         we;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_stall = 0;

  function automatic vec_t mk(string nm, logic iv, logic [3:0] ra1, logic [3:0] ra2,
                              logic [3:0] wa, logic we, logic [W-1:0] pc, logic [W-1:0] rd1,
                              logic [W-1:0] rd2, logic wbv, logic [3:0] wbwa, logic [W-1:0] wbwd,
                              logic ordy, logic rdy, logic haz, logic [W-1:0] e1, logic [W-1:0] e2);
    vec_t v;
    v.name = nm; v.iv = iv; v.ra1 = ra1; v.ra2 = ra2; v.wa = wa; v.we = we;
    v.pc = pc; v.rd1 = rd1; v.rd2 = rd2; v.wbv = wbv; v.wbwa = wbwa; v.wbwd = wbwd;
    v.ordy = ordy; v.rdy = rdy; v.haz = haz; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Entered at posedge+1: drive, compare handshake and scoreboard at negedge, step one clock.
  task automatic apply(input vec_t v);
    exp_t e;
    in_valid = v.iv; in_ra1 = v.ra1; in_ra2 = v.ra2; in_wa = v.wa; in_we = v.we;
    in_pc = v.pc; rf_rd1 = v.rd1; rf_rd2 = v.rd2;
    wb_valid = v.wbv; wb_wa = v.wbwa; wb_wd = v.wbwd; out_ready = v.ordy;
    @(negedge clk);
    chk({v.name, "/in_ready"}, W'(in_ready), W'(v.rdy));
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL %s/unexpected_out: got out_valid=1 expected nothing pending", v.name);
      end else begin
        e = sbq.pop_front();
        chk({v.name, "/out_op1"}, out_op1, e.op1);
        chk({v.name, "/out_op2"}, out_op2, e.op2);
        chk({v.name, "/out_wa"}, W'(out_wa), W'(e.wa));
        chk({v.name, "/out_we"}, W'(out_we), W'(e.we));
      end
    end
    if (v.iv && v.rdy) begin
      e.op1 = v.e1; e.op2 = v.e2; e.wa = v.wa; e.we = v.we;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    if (v.haz && exp_stall < 65535) exp_stall++;
    chk({v.name, "/stall_cnt"}, W'(stall_cnt), W'(exp_stall));
  endtask

  task automatic drained(input string nm);
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL %s/queue: got %0d outstanding expected 0", nm, sbq.size());
    end
    chk({nm, "/out_valid"}, W'(out_valid), W'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t idle;
    idle = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);

    tbl.push_back(mk("basic", 1, 1, 2, 0, 0, 0, 5, 7, 0, 0, 0, 1, 1, 0, 5, 7));
    tbl.push_back(mk("pc15", 1, 15, 2, 15, 1, 32'h100, 32'hBAD, 9, 0, 0, 0, 1, 1, 0, 32'h108, 9));
    tbl.push_back(mk("pcwrap", 1, 0, 15, 0, 0, 32'hFFFF_FFFC, 32'hA, 32'hBAD, 0, 0, 0, 1, 1, 0, 32'hA, 32'h4));
    tbl.push_back(idle);
    tbl.push_back(mk("wr_r3", 1, 1, 2, 3, 1, 0, 11, 12, 0, 0, 0, 1, 1, 0, 11, 12));
    tbl.push_back(mk("raw_r3_src2", 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk("raw_r3", 1, 3, 0, 0, 0, 0, 32'h111, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk("raw_r3", 1, 3, 0, 0, 0, 0, 32'h111, 0, 0, 0, 0, 1, 0, 1, 0, 0));
`ifdef FORWARD_EN
    tbl.push_back(mk("wb_r3", 1, 3, 0, 0, 0, 0, 32'h111, 0, 1, 3, 32'h333, 1, 1, 0, 32'h333, 0));
`else
    tbl.push_back(mk("wb_r3", 1, 3, 0, 0, 0, 0, 32'h111, 0, 1, 3, 32'h333, 1, 0, 1, 0, 0));
`endif
    tbl.push_back(mk("after_wb_r3", 1, 3, 0, 0, 0, 0, 32'h333, 0, 0, 0, 0, 1, 1, 0, 32'h333, 0));
    tbl.push_back(idle);
    tbl.push_back(mk("wr_r4", 1, 1, 2, 4, 1, 0, 1, 2, 0, 0, 0, 1, 1, 0, 1, 2));
`ifdef FORWARD_EN
    tbl.push_back(mk("fwd_r4", 1, 4, 5, 0, 0, 0, 32'h4444, 32'h55, 1, 4, 32'hDEAD, 1, 1, 0, 32'hDEAD, 32'h55));
`else
    tbl.push_back(mk("fwd_r4", 1, 4, 5, 0, 0, 0, 32'h4444, 32'h55, 1, 4, 32'hDEAD, 1, 0, 1, 0, 0));
`endif
    tbl.push_back(mk("after_wb_r4", 1, 4, 5, 0, 0, 0, 32'hDEAD, 32'h55, 0, 0, 0, 1, 1, 0, 32'hDEAD, 32'h55));
    tbl.push_back(idle);

    reset = 1'b0;
    in_valid = 1'b1; in_ra1 = 1; in_ra2 = 2; in_wa = 3; in_we = 1'b1; in_pc = 32'h40;
    rf_rd1 = 32'h1; rf_rd2 = 32'h2; wb_valid = 1'b0; wb_wa = 0; wb_wd = 0; out_ready = 1'b1;
    @(posedge clk);
    #2;
    chk("reset/in_ready", W'(in_ready), W'(0));
    chk("reset/out_valid", W'(out_valid), W'(0));
    chk("reset/out_op1", out_op1, 0);
    chk("reset/out_op2", out_op2, 0);
    chk("reset/out_wa", W'(out_wa), W'(0));
    chk("reset/out_we", W'(out_we), W'(0));
    chk("reset/stall_cnt", W'(stall_cnt), W'(0));
    chk("reset/pending", W'(dut.pending_q), W'(0));
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
    drained("table");
    chk("table/pending", W'(dut.pending_q), W'(0));

    // Held output with out_ready low, then a write issue that coincides with a writeback to the same register.
    apply(mk("hold_load", 1, 1, 2, 7, 0, 0, 32'h71, 32'h72, 0, 0, 0, 0, 1, 0, 32'h71, 32'h72));
    for (int k = 0; k < 3; k++) begin
      apply(mk("hold", 1, 8, 9, 0, 0, 0, 32'h81, 32'h82, 0, 0, 0, 0, 0, 0, 0, 0));
      chk("hold/out_valid", W'(out_valid), W'(1));
      chk("hold/out_op1", out_op1, 32'h71);
      chk("hold/out_op2", out_op2, 32'h72);
      chk("hold/out_wa", W'(out_wa), W'(7));
    end
    apply(mk("wr_r6_wb_r6", 1, 1, 2, 6, 1, 0, 32'h61, 32'h62, 1, 6, 32'h6666, 1, 1, 0, 32'h61, 32'h62));
    chk("set_wins/pending6", W'(dut.pending_q[6]), W'(1));
    apply(mk("raw_r6_wb_other", 1, 6, 0, 0, 0, 0, 32'h60, 0, 1, 9, 32'h99, 1, 0, 1, 0, 0));
`ifdef FORWARD_EN
    apply(mk("wb_r6", 1, 6, 0, 0, 0, 0, 32'h60, 0, 1, 6, 32'h66, 1, 1, 0, 32'h66, 0));
`else
    apply(mk("wb_r6", 1, 6, 0, 0, 0, 0, 32'h60, 0, 1, 6, 32'h66, 1, 0, 1, 0, 0));
`endif
    apply(mk("after_wb_r6", 1, 6, 0, 0, 0, 0, 32'h66, 0, 0, 0, 0, 1, 1, 0, 32'h66, 0));
    apply(idle);
    drained("hold_seq");
    chk("hold_seq/pending", W'(dut.pending_q), W'(0));

    // Long hazard to saturate the stall counter, leaving r1/r2 pending and an instruction held.
    apply(mk("wr_r1", 1, 0, 0, 1, 1, 0, 1, 2, 0, 0, 0, 1, 1, 0, 1, 2));
    apply(mk("wr_r2", 1, 0, 0, 2, 1, 0, 3, 4, 0, 0, 0, 1, 1, 0, 3, 4));
    in_valid = 1'b1; in_ra1 = 1; in_ra2 = 2; in_wa = 0; in_we = 1'b0;
    wb_valid = 1'b0; out_ready = 1'b0;
    repeat (65540) @(posedge clk);
    #1;
    chk("saturate/stall_cnt", W'(stall_cnt), W'(16'hFFFF));
    chk("saturate/out_valid", W'(out_valid), W'(1));
    chk("saturate/in_ready", W'(in_ready), W'(0));
    chk("saturate/pending", W'(dut.pending_q), W'(15'h0006));

    #2;
    reset = 1'b0;
    #1;
    chk("async_reset/out_valid", W'(out_valid), W'(0));
    chk("async_reset/in_ready", W'(in_ready), W'(0));
    chk("async_reset/stall_cnt", W'(stall_cnt), W'(0));
    chk("async_reset/out_op1", out_op1, 0);
    chk("async_reset/out_wa", W'(out_wa), W'(0));
    chk("async_reset/out_we", W'(out_we), W'(0));
    chk("async_reset/pending", W'(dut.pending_q), W'(0));
    sbq.delete();
    exp_stall = 0;
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    apply(mk("post_reset_r1", 1, 1, 2, 0, 0, 0, 32'h11, 32'h22, 0, 0, 0, 1, 1, 0, 32'h11, 32'h22));
    apply(idle);
    drained("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
